// File: rtl/imm_gen_pipe_pkg.sv
// Shared decode definitions for the immediate generator: format select encoding,
// legal datapath widths and the entry type held by the skid buffer.
package imm_gen_pipe_pkg;

   localparam int XLEN_32   = 32;
   localparam int XLEN_64   = 64;
   localparam int XLEN_MAX  = XLEN_64;
   localparam int TAG_W_MAX = 16;

   typedef enum logic [2:0] {
      IMM_I    = 3'd0,
      IMM_S    = 3'd1,
      IMM_J    = 3'd2,
      IMM_U    = 3'd3,
      IMM_B    = 3'd4,
      IMM_Z    = 3'd5,
      IMM_SH   = 3'd6,
      IMM_RSVD = 3'd7
   } imm_sel_t;

   // Sized for the widest legal configuration; narrower builds use the low bits.
   typedef struct packed {
      logic [XLEN_MAX-1:0]  immediate;
      logic [TAG_W_MAX-1:0] tag;
      logic                 illegal;
   } imm_entry_t;

   function automatic logic xlen_is_legal(input int xlen);
      return (xlen == XLEN_32) || (xlen == XLEN_64);
   endfunction

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Instruction-in / immediate-out stream bundle of the immediate generator.
// A word moves when valid && ready are both high at a rising clk edge; a source holds
// valid and its payload steady until that happens, and ready never depends on valid.
interface imm_gen_pipe_if #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) ();

   logic             in_valid;
   logic             in_ready;
   logic [31:0]      instruction;
   logic [2:0]       imm_select;
   logic [TAG_W-1:0] in_tag;

   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  immediate;
   logic [TAG_W-1:0] out_tag;
   logic             illegal;

   modport master (
      output in_valid, instruction, imm_select, in_tag, out_ready,
      input  in_ready, out_valid, immediate, out_tag, illegal
   );

   modport slave (
      input  in_valid, instruction, imm_select, in_tag, out_ready,
      output in_ready, out_valid, immediate, out_tag, illegal
   );

endinterface

// File: rtl/imm_gen_pipe_imm_extract.sv
// Combinational immediate extraction and extension for one RISC-V instruction word.
module imm_extract
   import imm_gen_pipe_pkg::*;
#(
   parameter int XLEN = XLEN_32
) (
   input  logic [31:0]     instruction,
   input  logic [2:0]      imm_select,
   output logic [XLEN-1:0] immediate,
   output logic            illegal
);

   imm_sel_t sel;
   logic     unused_opcode;

   assign sel           = imm_sel_t'(imm_select);
   assign unused_opcode = ^instruction[6:0];

   always_comb begin
      immediate = '0;
      illegal   = 1'b0;
      case (sel)
         IMM_I:  immediate = XLEN'($signed(instruction[31:20]));
         IMM_S:  immediate = XLEN'($signed({instruction[31:25], instruction[11:7]}));
         IMM_J:  immediate = XLEN'($signed({instruction[31], instruction[19:12],
                                            instruction[20], instruction[30:21], 1'b0}));
         IMM_U:  immediate = XLEN'($signed({instruction[31:12], 12'b0}));
         IMM_B:  immediate = XLEN'($signed({instruction[31], instruction[7],
                                            instruction[30:25], instruction[11:8], 1'b0}));
         IMM_Z:  immediate = XLEN'(instruction[19:15]);
         // RV64 shift amounts carry one more bit than RV32.
         IMM_SH: immediate = (XLEN == XLEN_64) ? XLEN'(instruction[25:20])
                                               : XLEN'(instruction[24:20]);
         default: begin
            immediate = '0;
            illegal   = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: extraction feeding a 2-entry valid/ready skid buffer.
// Optional flush port enabled by defining IMM_PIPE_FLUSH_EN.
module imm_gen_pipe
   import imm_gen_pipe_pkg::*;
#(
   parameter int XLEN  = XLEN_32,
   parameter int TAG_W = 5
) (
   input  logic clk,
   input  logic reset_n,
`ifdef IMM_PIPE_FLUSH_EN
   input  logic flush,
`endif
   imm_gen_pipe_if.slave bus
);

   logic [XLEN-1:0] ext_immediate;
   logic            ext_illegal;
   imm_entry_t      new_entry;
   imm_entry_t      main_q;
   imm_entry_t      skid_q;
   logic            main_valid;
   logic            skid_valid;
   logic            flush_req;
   logic            accept;
   logic            drain;
   logic            unused_pad;

   imm_extract #(.XLEN(XLEN)) u_imm_extract (
      .instruction (bus.instruction),
      .imm_select  (bus.imm_select),
      .immediate   (ext_immediate),
      .illegal     (ext_illegal)
   );

`ifdef IMM_PIPE_FLUSH_EN
   assign flush_req = flush;
`else
   assign flush_req = 1'b0;
`endif

   always_comb begin
      new_entry           = '0;
      new_entry.immediate = XLEN_MAX'(ext_immediate);
      new_entry.tag       = TAG_W_MAX'(bus.in_tag);
      new_entry.illegal   = ext_illegal;
   end

   // in_ready comes from registered state only, so it never combinationally follows out_ready.
   assign bus.in_ready = !skid_valid;
   assign accept       = bus.in_valid && !skid_valid && !flush_req;
   assign drain        = main_valid && bus.out_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
         main_q     <= '0;
         skid_q     <= '0;
      end else if (flush_req) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
      end else if (drain) begin
         if (skid_valid) begin
            // No accept is possible here: in_ready is low while skid is occupied.
            main_q     <= skid_q;
            main_valid <= 1'b1;
            skid_valid <= 1'b0;
         end else if (accept) begin
            main_q     <= new_entry;
            main_valid <= 1'b1;
         end else begin
            main_valid <= 1'b0;
         end
      end else if (accept) begin
         if (!main_valid) begin
            main_q     <= new_entry;
            main_valid <= 1'b1;
         end else begin
            skid_q     <= new_entry;
            skid_valid <= 1'b1;
         end
      end
   end

   assign bus.out_valid = main_valid;
   assign bus.immediate = main_q.immediate[XLEN-1:0];
   assign bus.out_tag   = main_q.tag[TAG_W-1:0];
   assign bus.illegal   = main_q.illegal;

   // Padding bits above XLEN/TAG_W are stored but never presented.
   assign unused_pad = ^{main_q.immediate, main_q.tag};

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share one stimulus stream.
// Flush scenario is exercised when IMM_PIPE_FLUSH_EN is defined.
`timescale 1ns/1ps
module tb_imm_gen_pipe;

   localparam int TAG_W = 5;
   localparam int EW    = 1 + TAG_W + 64;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic             in_valid = 1'b0;
   logic [31:0]      instruction = '0;
   logic [2:0]       imm_select = '0;
   logic [TAG_W-1:0] in_tag = '0;
   logic             out_ready = 1'b0;
   logic             flush_tb = 1'b0;

   logic [EW-1:0] exp_q32[$];
   logic [EW-1:0] exp_q64[$];
   int            n_cmp = 0;
   int            n_fail = 0;
   int            occ = 0;
   logic          rand_done = 1'b0;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   imm_gen_pipe_if #(.XLEN(32), .TAG_W(TAG_W)) if32 ();
   imm_gen_pipe_if #(.XLEN(64), .TAG_W(TAG_W)) if64 ();

   assign if32.in_valid    = in_valid;
   assign if32.instruction = instruction;
   assign if32.imm_select  = imm_select;
   assign if32.in_tag      = in_tag;
   assign if32.out_ready   = out_ready;
   assign if64.in_valid    = in_valid;
   assign if64.instruction = instruction;
   assign if64.imm_select  = imm_select;
   assign if64.in_tag      = in_tag;
   assign if64.out_ready   = out_ready;

   imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W)) dut32 (
      .clk     (clk),
      .reset_n (reset_n),
`ifdef IMM_PIPE_FLUSH_EN
      .flush   (flush_tb),
`endif
      .bus     (if32)
   );

   imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W)) dut64 (
      .clk     (clk),
      .reset_n (reset_n),
`ifdef IMM_PIPE_FLUSH_EN
      .flush   (flush_tb),
`endif
      .bus     (if64)
   );

   // ---------------- reference model ----------------
   function automatic logic [63:0] ref_imm(input logic [31:0] ins, input int sel, input int xlen);
      longint u;
      longint v;
      logic [63:0] r;
      u = longint'({32'b0, ins});
      case (sel)
         0: begin
            v = (u >> 20) & 'hFFF;
            if (v >= 2048) v = v - 4096;
         end
         1: begin
            v = (((u >> 25) & 'h7F) << 5) | ((u >> 7) & 'h1F);
            if (v >= 2048) v = v - 4096;
         end
         2: begin
            v = (((u >> 31) & 1) << 20) | (((u >> 12) & 'hFF) << 12)
              | (((u >> 20) & 1) << 11) | (((u >> 21) & 'h3FF) << 1);
            if (v >= (longint'(1) << 20)) v = v - (longint'(1) << 21);
         end
         3: begin
            v = u & 'hFFFFF000;
            if (v >= (longint'(1) << 31)) v = v - (longint'(1) << 32);
         end
         4: begin
            v = (((u >> 31) & 1) << 12) | (((u >> 7) & 1) << 11)
              | (((u >> 25) & 'h3F) << 5) | (((u >> 8) & 'hF) << 1);
            if (v >= 4096) v = v - 8192;
         end
         5: v = (u >> 15) & 'h1F;
         6: v = (u >> 20) & ((xlen == 64) ? 'h3F : 'h1F);
         default: v = 0;
      endcase
      r = 64'(v);
      if (xlen == 32) r[63:32] = '0;
      return r;
   endfunction

   function automatic logic [EW-1:0] model(input logic [31:0] ins, input logic [2:0] sel,
                                           input logic [TAG_W-1:0] tag, input int xlen);
      return {(sel == 3'd7), tag, ref_imm(ins, int'(sel), xlen)};
   endfunction

   // Occupancy of the block: entries accepted and not yet delivered.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) occ <= 0;
      else if (flush_tb) occ <= 0;
      else occ <= occ + int'(in_valid && (occ < 2)) - int'((occ > 0) && out_ready);
   end

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [EW-1:0] got, input logic [EW-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (reset_n) begin
         check("in_ready32", EW'(if32.in_ready), EW'(occ < 2));
         check("out_valid32", EW'(if32.out_valid), EW'(occ > 0));
         check("in_ready64", EW'(if64.in_ready), EW'(occ < 2));
         check("out_valid64", EW'(if64.out_valid), EW'(occ > 0));
         if (if32.out_valid && out_ready) begin
            if (exp_q32.size() == 0) begin
               n_cmp++; n_fail++;
               $display("FAIL out32: unexpected delivery tag %0d, expected none", if32.out_tag);
            end else begin
               check("out32", {if32.illegal, if32.out_tag, 32'b0, if32.immediate}, exp_q32.pop_front());
            end
         end
         if (if64.out_valid && out_ready) begin
            if (exp_q64.size() == 0) begin
               n_cmp++; n_fail++;
               $display("FAIL out64: unexpected delivery tag %0d, expected none", if64.out_tag);
            end else begin
               check("out64", {if64.illegal, if64.out_tag, if64.immediate}, exp_q64.pop_front());
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send(input logic [31:0] ins, input logic [2:0] sel, input logic [TAG_W-1:0] tag);
      int wait_n = 0;
      @(posedge clk); #1;
      in_valid = 1'b1; instruction = ins; imm_select = sel; in_tag = tag;
      while (!if32.in_ready && wait_n < 50) begin
         @(posedge clk); #1;
         wait_n++;
      end
      if (!if32.in_ready) begin
         n_cmp++; n_fail++;
         $display("FAIL send_timeout: in_ready 0 for %0d cycles, expected 1", wait_n);
      end else begin
         exp_q32.push_back(model(ins, sel, tag, 32));
         exp_q64.push_back(model(ins, sel, tag, 64));
      end
   endtask

   task automatic idle();
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic check_empty_state(input string tag_name);
      check({tag_name, "_out_valid32"}, EW'(if32.out_valid), EW'(0));
      check({tag_name, "_in_ready32"},  EW'(if32.in_ready),  EW'(1));
      check({tag_name, "_out_valid64"}, EW'(if64.out_valid), EW'(0));
      check({tag_name, "_in_ready64"},  EW'(if64.in_ready),  EW'(1));
   endtask

   task automatic drain_all();
      int n = 0;
      out_ready = 1'b1;
      while ((exp_q32.size() != 0 || exp_q64.size() != 0) && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      repeat (2) @(posedge clk);
      #1;
      check("drain32_left", EW'(exp_q32.size()), EW'(0));
      check("drain64_left", EW'(exp_q64.size()), EW'(0));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      repeat (2) @(posedge clk);
      #1;
      check_empty_state("reset");
      check("reset_data32", {if32.illegal, if32.out_tag, 32'b0, if32.immediate}, EW'(0));
      check("reset_data64", {if64.illegal, if64.out_tag, if64.immediate}, EW'(0));
      @(negedge clk); reset_n = 1'b1;

      // Directed formats.
      out_ready = 1'b1;
      send(32'hFFF00093, 3'd0, 5'd1);
      send(32'hFE112E23, 3'd1, 5'd2);
      send(32'h800000B7, 3'd3, 5'd3);
      send(32'h03F0D093, 3'd6, 5'd4);
      send(32'h000FD073, 3'd5, 5'd5);
      send(32'h12345678, 3'd7, 5'd6);
      send(32'hFE000EE3, 3'd4, 5'd7);
      send(32'h8000006F, 3'd2, 5'd8);
      idle();
      repeat (3) @(posedge clk);

      // Continuous stream with a three-cycle downstream stall.
      fork
         begin
            for (int t = 1; t <= 8; t++) send($urandom(), 3'($urandom_range(0, 6)), TAG_W'(t));
            idle();
         end
         begin
            repeat (2) @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      drain_all();

      // Randomized traffic with random backpressure.
      fork
         begin
            for (int n = 0; n < 300; n++) begin
               send($urandom(), 3'($urandom_range(0, 7)), TAG_W'($urandom()));
               if ($urandom_range(0, 3) == 0) idle();
            end
            idle();
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               @(posedge clk); #1;
               out_ready = ($urandom_range(0, 9) < 7);
            end
         end
      join
      drain_all();

      // Asynchronous reset with both entries held.
      out_ready = 1'b0;
      send(32'hFFF00093, 3'd0, 5'd9);
      send(32'hFE112E23, 3'd1, 5'd10);
      idle();
      @(posedge clk); #3;
      reset_n = 1'b0;
      #1;
      check_empty_state("async_reset");
      exp_q32.delete();
      exp_q64.delete();
      @(negedge clk); #1 reset_n = 1'b1;
      out_ready = 1'b1;
      send(32'h800000B7, 3'd3, 5'd11);
      idle();
      drain_all();

`ifdef IMM_PIPE_FLUSH_EN
      // Flush with both entries held and a new word offered in the same cycle.
      out_ready = 1'b0;
      send(32'h00500093, 3'd0, 5'd12);
      send(32'h00600093, 3'd0, 5'd13);
      @(posedge clk); #1;
      in_valid = 1'b1; instruction = 32'hFFF00093; imm_select = 3'd0; in_tag = 5'd31;
      flush_tb = 1'b1;
      @(posedge clk); #1;
      flush_tb = 1'b0;
      in_valid = 1'b0;
      check_empty_state("flush");
      exp_q32.delete();
      exp_q64.delete();
      drain_all();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
